imem_loader: RTL
================

# imem_loader

Program loader and CPU-hold controller for the 256x15-bit instruction memory. It accepts a framed byte stream over a valid/ready handshake, assembles 15-bit instructions, and drives the instruction memory write port with sequential addresses from 0. It verifies an XOR checksum and holds the CPU halted until a load completes successfully. It sits between the host/UART byte receiver and the instruction memory, beside the CPU top.

## Interface
- ADDR_W, 8, instruction memory address width (depth 2**ADDR_W)
- INSTR_W, 15, instruction width (must be ≤ 16)
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  single-cycle load request
- byte_valid_i  in  1  byte_i holds a valid byte
- byte_i  in  8  stream byte
- byte_ready_o  out  1  loader accepts a byte this cycle
- we_o  out  1  instruction memory write enable (one cycle per word)
- waddr_o  out  ADDR_W  write address
- wdata_o  out  INSTR_W  write data
- busy_o  out  1  load in progress
- done_o  out  1  last load succeeded (sticky)
- error_o  out  1  last load failed (sticky)
- cpu_halt_o  out  1  hold CPU (PC and state) frozen

## Operation
- Frame: LEN byte N (N=0 means 256 words), then N × {HI, LO}, then CHK byte.
- Word = {HI[INSTR_W-9:0], LO}. With INSTR_W=15: HI[6:0] gives bits 14:8, and HI[7] must be 0.
- Checksum: XOR of all HI and LO bytes (LEN excluded). It must equal CHK.
- Byte transfer occurs when byte_valid_i && byte_ready_o at a rising edge.
- States:
  - IDLE: ready=0. start_i → LEN; clears done, error and the checksum accumulator; address counter set to 0.
  - LEN: ready=1. On accept, latch the word count and go to HI.
  - HI: ready=1. On accept, latch the byte and go to LO. If HI[7]=1 → ERR.
  - LO: ready=1. On accept → WR.
  - WR: ready=0. we_o=1 with the current address/data. Then increment the address. If the words remaining are 0 → CHK, else → HI.
  - CHK: ready=1. On accept → DONE if it matches, else ERR.
  - DONE: done_o=1, cpu_halt_o=0, go to IDLE.
  - ERR: error_o=1, cpu_halt_o=1, go to IDLE.
- start_i is ignored while busy_o=1. start_i in IDLE restarts a load, which re-asserts cpu_halt_o.
- The address counter is ADDR_W bits. With N=256 the last write is at 255. The counter wrapping to 0 is harmless; words are counted separately with ADDR_W+1 bits.
- Memory contents beyond N words are untouched.

## Timing
- Reset values: byte_ready_o=0, we_o=0, waddr_o=0, wdata_o=0, busy_o=0, done_o=0, error_o=0, cpu_halt_o=1.
- All outputs are registered or decoded from state only. There is no combinational path from byte_valid_i to any output.
- busy_o=1 in LEN, HI, LO, WR and CHK.
- Load duration, with bytes available every accept cycle: 1 (LEN) + 3N (HI, LO, WR) + 1 (CHK) + 1 (DONE/ERR) cycles after the start cycle.
- we_o goes high the cycle after LO is accepted and stays high for exactly 1 cycle. waddr_o/wdata_o are stable while we_o=1.
- done_o/error_o assert the cycle after CHK (or a bad HI) is accepted. They hold until the next accepted start_i or rst_i.
- cpu_halt_o:
  - deasserts the same cycle done_o asserts;
  - re-asserts the cycle after start_i is accepted.
- byte_valid_i may drop at any time. The FSM waits in its state with no timeout.
- rst_i mid-load returns to IDLE with reset values. Partially written memory is left as-is, and the CPU stays halted.
- rst_i together with start_i: reset wins.

## Structure
- Shared package manquehuito_pkg:
  - IMEM_ADDR_W=8, INSTR_W=15 constants;
  - loader_state_e enum (IDLE, LEN, HI, LO, WR, CHK, DONE, ERR).
- Single module, no sub-module. The checksum accumulator, word counter and address counter are inline registers.
- The instruction memory gains a synchronous write port (we, waddr, wdata). The read path is unchanged.

## Test plan
- Basic load: start, stream LEN=2, 0x12, 0x34, 0x7F, 0xFF, CHK=0x12^0x34^0x7F^0xFF=0xA6.
  - Expect writes 0→0x1234 and 1→0x7FFF.
  - Expect done_o=1, cpu_halt_o=0, error_o=0.
- Bad checksum: same frame with CHK=0x00.
  - Both writes occur.
  - error_o=1, cpu_halt_o=1, done_o=0.
- Illegal HI: LEN=1, HI=0x80.
  - Expect error_o=1 the next cycle and no we_o pulse.
  - byte_ready_o=0 after the error.
- Full depth: LEN=0, 256 words of value i (HI=0, LO=i), correct CHK.
  - Expect 256 we_o pulses, addresses 0..255 in order.
  - Expect done_o=1 and no extra write.
- Backpressure and stalls: toggle byte_valid_i randomly. Also pulse start_i mid-load.
  - Data written is identical to the no-stall run.
  - start_i has no effect while busy.
- Reset mid-load: assert rst_i after the first HI.
  - All outputs return to reset values next cycle; cpu_halt_o=1.
  - A subsequent full load succeeds.

Source files
------------

// File: rtl/manquehuito_pkg.sv
// Shared constants, loader FSM state encoding and stream-format helpers
// for the instruction-memory loader and its neighbours.
package manquehuito_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int INSTR_W     = 15;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    WR   = 3'd4,
    CHK  = 3'd5,
    DONE = 3'd6,
    ERR  = 3'd7
  } loader_state_e;

  // A HI byte is legal only when every bit above the instruction's top bit is zero.
  function automatic logic hi_is_legal(input logic [7:0] hi, input int instr_w);
    logic [7:0] upper;
    upper = hi >> (instr_w - 8);
    return (upper == 8'd0);
  endfunction

  // Running XOR checksum step over the HI/LO payload bytes.
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles instructions, writes them to
// the instruction memory from address 0, checks an XOR checksum, holds the CPU.
module imem_loader
  import manquehuito_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int INSTR_W = manquehuito_pkg::INSTR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic               byte_ready_o,
  output logic               we_o,
  output logic [ADDR_W-1:0]  waddr_o,
  output logic [INSTR_W-1:0] wdata_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic               cpu_halt_o
);

  // LEN=0 encodes a full-depth load, so the word counter needs one extra bit.
  localparam logic [ADDR_W:0] WORDS_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] WORDS_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_e      state_r;
  loader_state_e      state_next_s;
  logic               accept_s;
  logic               hi_ok_s;
  logic               chk_ok_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W:0]    words_r;
  logic [INSTR_W-9:0] hi_r;
  logic [INSTR_W-1:0] wdata_r;
  logic [7:0]         chk_r;
  logic               done_r;
  logic               error_r;
  logic               halt_r;

  assign byte_ready_o = (state_r == LEN) || (state_r == HI) ||
                        (state_r == LO)  || (state_r == CHK);
  assign busy_o       = byte_ready_o || (state_r == WR);
  assign we_o         = (state_r == WR);
  assign waddr_o      = addr_r;
  assign wdata_o      = wdata_r;
  assign done_o       = done_r;
  assign error_o      = error_r;
  assign cpu_halt_o   = halt_r;

  assign accept_s = byte_valid_i && byte_ready_o;
  assign hi_ok_s  = hi_is_legal(byte_i, INSTR_W);
  assign chk_ok_s = (byte_i == chk_r);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; byte-consuming states wait indefinitely for a byte.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_next_s = LEN;
        end else begin
          state_next_s = IDLE;
        end
      end
      LEN: begin
        if (accept_s) begin
          state_next_s = HI;
        end else begin
          state_next_s = LEN;
        end
      end
      HI: begin
        if (accept_s) begin
          if (hi_ok_s) begin
            state_next_s = LO;
          end else begin
            state_next_s = ERR;
          end
        end else begin
          state_next_s = HI;
        end
      end
      LO: begin
        if (accept_s) begin
          state_next_s = WR;
        end else begin
          state_next_s = LO;
        end
      end
      WR: begin
        if (words_r == WORDS_ONE) begin
          state_next_s = CHK;
        end else begin
          state_next_s = HI;
        end
      end
      CHK: begin
        if (accept_s) begin
          if (chk_ok_s) begin
            state_next_s = DONE;
          end else begin
            state_next_s = ERR;
          end
        end else begin
          state_next_s = CHK;
        end
      end
      DONE:    state_next_s = IDLE;
      ERR:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: counters, instruction assembly, checksum and sticky status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_r  <= '0;
      words_r <= '0;
      hi_r    <= '0;
      wdata_r <= '0;
      chk_r   <= 8'd0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      halt_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            addr_r  <= '0;
            chk_r   <= 8'd0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            halt_r  <= 1'b1;
          end
        end
        LEN: begin
          if (accept_s) begin
            words_r <= (byte_i == 8'd0) ? WORDS_FULL : (ADDR_W+1)'(byte_i);
          end
        end
        HI: begin
          if (accept_s) begin
            hi_r  <= byte_i[INSTR_W-9:0];
            chk_r <= chk_step(chk_r, byte_i);
            if (!hi_ok_s) begin
              error_r <= 1'b1;
            end
          end
        end
        LO: begin
          if (accept_s) begin
            wdata_r <= {hi_r, byte_i};
            chk_r   <= chk_step(chk_r, byte_i);
          end
        end
        WR: begin
          // After a full-depth load the address wraps to 0; words_r decides termination.
          addr_r  <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          words_r <= words_r - WORDS_ONE;
        end
        CHK: begin
          if (accept_s) begin
            if (chk_ok_s) begin
              done_r <= 1'b1;
              halt_r <= 1'b0;
            end else begin
              error_r <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
